intdiv_r2_multi: RTL and testbench

- Parametrised iterative integer divider, radix-2 restoring, with leading-zero pre-alignment so the loop only runs over significant quotient bits.
- Successor to the fixed-width radix-16 divider. Adds a half-width (word) mode, such as 32-bit ops on a 64-bit datapath with sign-extended results, and data-dependent latency.
- Sits behind the integer issue queue, with a valid/ready interface on both start and finish sides.

---
 rtl/intdiv_r2_multi.sv | 221 ++++++++++++++++++++++
 tb/tb_intdiv_r2_multi.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intdiv_r2_multi.sv
// Iterative radix-2 restoring integer divider with leading-zero pre-alignment.
// Supports signed/unsigned operation and an optional half-width (word) mode
// whose results are sign-extended to the full datapath width.
module intdiv_r2_multi #(
  parameter int D_W     = 64,
  parameter bit WORD_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush_i,
  input  logic           start_valid_i,
  output logic           start_ready_o,
  input  logic           signed_op_i,
  input  logic           word_op_i,
  input  logic [D_W-1:0] dividend_i,
  input  logic [D_W-1:0] divisor_i,
  output logic           finish_valid_o,
  input  logic           finish_ready_i,
  output logic [D_W-1:0] quotient_o,
  output logic [D_W-1:0] remainder_o,
  output logic           divisor_is_zero_o
);

  localparam int H  = D_W / 2;
  localparam int CW = $clog2(D_W) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ITER,
    S_POST,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Operands captured at the start handshake; they stay untouched until the
  // next accepted operation, so PRE and POST can both derive flags from them.
  logic [D_W-1:0] r_dvd;
  logic [D_W-1:0] r_dvs;
  logic           r_signed;
  logic           r_word;

  // Iteration datapath: one extra bit on remainder/divisor so no carry is lost.
  logic [D_W:0]   r_rem;
  logic [D_W:0]   r_div;
  logic [D_W-1:0] r_q;
  logic [CW-1:0]  r_cnt;

  logic [D_W-1:0] r_quotient;
  logic [D_W-1:0] r_remainder;
  logic           r_div_zero;

  // Count of leading zeros over the full datapath. The difference of two such
  // counts is independent of the effective width, so word mode reuses it.
  function automatic logic [CW-1:0] lzc(input logic [D_W-1:0] x);
    logic [CW-1:0] n;
    logic          found;
    n     = CW'(D_W);
    found = 1'b0;
    for (int i = D_W - 1; i >= 0; i--) begin
      if (!found && x[i]) begin
        n     = CW'(D_W - 1 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  function automatic logic [D_W-1:0] sext_half(input logic [D_W-1:0] x);
    return {{H{x[H-1]}}, x[H-1:0]};
  endfunction

  logic           w_start_fire;
  logic           w_word;
  logic [D_W-1:0] w_dvd_ext;
  logic [D_W-1:0] w_dvs_ext;
  logic           w_dvd_neg;
  logic           w_dvs_neg;
  logic [D_W-1:0] w_dvd_abs;
  logic [D_W-1:0] w_dvs_abs;
  logic [D_W-1:0] w_min;
  logic           w_dvs_zero;
  logic           w_ovf;
  logic           w_small;
  logic [CW-1:0]  w_lzc_dvd;
  logic [CW-1:0]  w_lzc_dvs;
  logic [CW-1:0]  w_k;
  logic [CW-1:0]  w_shift;
  logic [D_W:0]   w_diff;
  logic           w_ge;
  logic [D_W-1:0] w_q_raw;
  logic [D_W-1:0] w_r_raw;
  logic [D_W-1:0] w_q_fin;
  logic [D_W-1:0] w_r_fin;

  assign w_start_fire = (r_state == S_IDLE) && start_valid_i && !flush_i;
  assign w_word       = WORD_EN && r_word;

  // Operands reduced to the effective width and extended back to D_W.
  assign w_dvd_ext = !w_word ? r_dvd :
                     (r_signed ? sext_half(r_dvd) : {{H{1'b0}}, r_dvd[H-1:0]});
  assign w_dvs_ext = !w_word ? r_dvs :
                     (r_signed ? sext_half(r_dvs) : {{H{1'b0}}, r_dvs[H-1:0]});

  assign w_dvd_neg = r_signed && w_dvd_ext[D_W-1];
  assign w_dvs_neg = r_signed && w_dvs_ext[D_W-1];
  assign w_dvd_abs = w_dvd_neg ? -w_dvd_ext : w_dvd_ext;
  assign w_dvs_abs = w_dvs_neg ? -w_dvs_ext : w_dvs_ext;

  // Most negative value of the effective width, already sign-extended.
  assign w_min = w_word ? {{H{1'b1}}, 1'b1, {(H-1){1'b0}}} : {1'b1, {(D_W-1){1'b0}}};

  assign w_dvs_zero = (w_dvs_ext == '0);
  assign w_ovf      = r_signed && (w_dvd_ext == w_min) && (w_dvs_ext == '1);
  assign w_small    = (w_dvd_abs < w_dvs_abs);

  assign w_lzc_dvd = lzc(w_dvd_abs);
  assign w_lzc_dvs = lzc(w_dvs_abs);
  assign w_k       = (w_dvs_zero || w_ovf || w_small) ? '0
                   : (w_lzc_dvs - w_lzc_dvd + CW'(1));
  assign w_shift   = (w_k == '0) ? '0 : (w_k - CW'(1));

  // Trial subtraction for the current quotient bit.
  assign w_diff = r_rem - r_div;
  assign w_ge   = (r_rem >= r_div);

  // Result formation from the magnitude quotient/remainder and special cases.
  always_comb begin
    w_q_raw = '0;
    w_r_raw = '0;
    if (w_dvs_zero) begin
      w_q_raw = '1;
      w_r_raw = w_dvd_ext;
    end else if (w_ovf) begin
      w_q_raw = w_min;
      w_r_raw = '0;
    end else if (w_small) begin
      w_q_raw = '0;
      w_r_raw = w_dvd_ext;
    end else begin
      w_q_raw = (w_dvd_neg ^ w_dvs_neg) ? -r_q : r_q;
      w_r_raw = w_dvd_neg ? -r_rem[D_W-1:0] : r_rem[D_W-1:0];
    end
  end

  assign w_q_fin = w_word ? sext_half(w_q_raw) : w_q_raw;
  assign w_r_fin = w_word ? sext_half(w_r_raw) : w_r_raw;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state and handshake outputs; flush overrides every transition.
  always_comb begin
    w_state_next   = r_state;
    start_ready_o  = (r_state == S_IDLE);
    finish_valid_o = (r_state == S_DONE);
    if (flush_i) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (start_valid_i) w_state_next = S_PRE;
        S_PRE:  w_state_next = (w_k == '0) ? S_POST : S_ITER;
        S_ITER: if (r_cnt == CW'(1)) w_state_next = S_POST;
        S_POST: w_state_next = S_DONE;
        S_DONE: if (finish_ready_i) w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Operand capture, alignment, restoring iteration and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_signed    <= 1'b0;
      r_word      <= 1'b0;
      r_rem       <= '0;
      r_div       <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_div_zero  <= 1'b0;
    end else begin
      if (w_start_fire) begin
        r_dvd    <= dividend_i;
        r_dvs    <= divisor_i;
        r_signed <= signed_op_i;
        r_word   <= word_op_i;
      end
      if (r_state == S_PRE) begin
        r_rem <= {1'b0, w_dvd_abs};
        r_div <= {1'b0, w_dvs_abs} << w_shift;
        r_q   <= '0;
        r_cnt <= w_k;
      end
      if (r_state == S_ITER) begin
        r_rem <= w_ge ? w_diff : r_rem;
        r_q   <= {r_q[D_W-2:0], w_ge};
        r_div <= r_div >> 1;
        r_cnt <= r_cnt - CW'(1);
      end
      if ((r_state == S_POST) && !flush_i) begin
        r_quotient  <= w_q_fin;
        r_remainder <= w_r_fin;
        r_div_zero  <= w_dvs_zero;
      end
    end
  end

  assign quotient_o        = r_quotient;
  assign remainder_o       = r_remainder;
  assign divisor_is_zero_o = r_div_zero;

endmodule

// File: tb/tb_intdiv_r2_multi.sv
// Self-checking bench for intdiv_r2_multi: directed cases from the divider's
// behaviour list plus randomized operations against an arithmetic model.
module tb_intdiv_r2_multi;

  localparam int D_W = 64;

  logic           clk;
  logic           rst;
  logic           flush_i;
  logic           start_valid_i;
  logic           start_ready_o;
  logic           signed_op_i;
  logic           word_op_i;
  logic [D_W-1:0] dividend_i;
  logic [D_W-1:0] divisor_i;
  logic           finish_valid_o;
  logic           finish_ready_i;
  logic [D_W-1:0] quotient_o;
  logic [D_W-1:0] remainder_o;
  logic           divisor_is_zero_o;

  intdiv_r2_multi #(.D_W(D_W), .WORD_EN(1'b1)) dut (
    .clk               (clk),
    .rst               (rst),
    .flush_i           (flush_i),
    .start_valid_i     (start_valid_i),
    .start_ready_o     (start_ready_o),
    .signed_op_i       (signed_op_i),
    .word_op_i         (word_op_i),
    .dividend_i        (dividend_i),
    .divisor_i         (divisor_i),
    .finish_valid_o    (finish_valid_o),
    .finish_ready_i    (finish_ready_i),
    .quotient_o        (quotient_o),
    .remainder_o       (remainder_o),
    .divisor_is_zero_o (divisor_is_zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        z;
    int          k;
    int          c0;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t exp_q[$];
  bit   head_seen = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [63:0] sext32(input logic [63:0] x);
    return {{32{x[31]}}, x[31:0]};
  endfunction

  function automatic int msb(input logic [63:0] x);
    int m = 0;
    for (int i = 0; i < 64; i++) if (x[i]) m = i;
    return m;
  endfunction

  // Reference: plain integer division on the effective-width operands.
  function automatic exp_t model(input logic [63:0] a_in, input logic [63:0] b_in,
                                 input logic s, input logic w);
    exp_t        e;
    logic [63:0] a, b, aa, ba, mn;
    if (w) begin
      a = s ? sext32(a_in) : {32'b0, a_in[31:0]};
      b = s ? sext32(b_in) : {32'b0, b_in[31:0]};
      mn = 64'hFFFF_FFFF_8000_0000;
    end else begin
      a = a_in;
      b = b_in;
      mn = 64'h8000_0000_0000_0000;
    end
    aa = (s && a[63]) ? -a : a;
    ba = (s && b[63]) ? -b : b;
    e.z = (b == 64'd0);
    e.k = 0;
    e.c0 = 0;
    if (b == 64'd0) begin
      e.q = '1;
      e.r = w ? sext32(a_in) : a_in;
    end else if (s && a == mn && b == '1) begin
      e.q = mn;
      e.r = 64'd0;
    end else begin
      if (s) begin
        e.q = $signed(a) / $signed(b);
        e.r = $signed(a) % $signed(b);
      end else begin
        e.q = a / b;
        e.r = a % b;
      end
      if (aa >= ba) e.k = msb(aa) - msb(ba) + 1;
    end
    if (w) begin
      e.q = sext32(e.q);
      e.r = sext32(e.r);
    end
    return e;
  endfunction

  // Cycle-by-cycle compare of the DUT against the queue of in-flight operations.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      exp_q.delete();
      head_seen = 1'b0;
      chk("reset_start_ready", {63'b0, start_ready_o}, 64'd1);
      chk("reset_finish_valid", {63'b0, finish_valid_o}, 64'd0);
    end else begin
      chk("start_ready", {63'b0, start_ready_o}, {63'b0, exp_q.size() == 0});
      if (finish_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_finish_valid", {63'b0, finish_valid_o}, 64'd0);
        end else begin
          if (!head_seen) begin
            head_seen = 1'b1;
            chk("latency", 64'(cyc - exp_q[0].c0), 64'(exp_q[0].k + 3));
          end
          chk("quotient", quotient_o, exp_q[0].q);
          chk("remainder", remainder_o, exp_q[0].r);
          chk("div_zero", {63'b0, divisor_is_zero_o}, {63'b0, exp_q[0].z});
        end
      end else if (exp_q.size() != 0) begin
        if (head_seen) begin
          chk("finish_valid_dropped", {63'b0, finish_valid_o}, 64'd1);
          head_seen = 1'b0;
        end else if (cyc - exp_q[0].c0 > exp_q[0].k + 3) begin
          chk("finish_late", 64'(cyc - exp_q[0].c0), 64'(exp_q[0].k + 3));
          head_seen = 1'b1;
        end
      end
      if (flush_i) begin
        exp_q.delete();
        head_seen = 1'b0;
      end else begin
        if (finish_valid_o && finish_ready_i && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          head_seen = 1'b0;
        end
        if (start_valid_i && start_ready_o) begin
          e = model(dividend_i, divisor_i, signed_op_i, word_op_i);
          e.c0 = cyc;
          exp_q.push_back(e);
        end
      end
    end
  end

  // Issue one operation from IDLE, wait for the result, hold backpressure,
  // then complete the finish handshake.
  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                       input logic w, input bit lit, input logic [63:0] eq,
                       input logic [63:0] er, input logic ez, input int hold,
                       input string tag);
    int          n;
    logic [63:0] hq, hr;
    start_valid_i = 1'b1;
    dividend_i    = a;
    divisor_i     = b;
    signed_op_i   = s;
    word_op_i     = w;
    @(posedge clk); #1;
    start_valid_i = 1'b0;
    dividend_i    = {$urandom, $urandom};
    divisor_i     = {$urandom, $urandom};
    signed_op_i   = 1'($urandom);
    word_op_i     = 1'($urandom);
    n = 0;
    while (!finish_valid_o && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!finish_valid_o) begin
      chk({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      if (lit) begin
        chk({tag, "_q"}, quotient_o, eq);
        chk({tag, "_r"}, remainder_o, er);
        chk({tag, "_z"}, {63'b0, divisor_is_zero_o}, {63'b0, ez});
      end
      hq = quotient_o;
      hr = remainder_o;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk({tag, "_hold_q"}, quotient_o, hq);
        chk({tag, "_hold_r"}, remainder_o, hr);
        chk({tag, "_hold_ready"}, {63'b0, start_ready_o}, 64'd0);
        chk({tag, "_hold_valid"}, {63'b0, finish_valid_o}, 64'd1);
      end
      finish_ready_i = 1'b1;
      @(posedge clk); #1;
      finish_ready_i = 1'b0;
      chk({tag, "_idle_ready"}, {63'b0, start_ready_o}, 64'd1);
      chk({tag, "_idle_valid"}, {63'b0, finish_valid_o}, 64'd0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout actual=%0d required=<%0d", cyc, cyc);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    exp_t        m;
    logic [63:0] a, b;
    logic        s, w;

    rst            = 1'b1;
    flush_i        = 1'b0;
    start_valid_i  = 1'b0;
    signed_op_i    = 1'b0;
    word_op_i      = 1'b0;
    dividend_i     = '0;
    divisor_i      = '0;
    finish_ready_i = 1'b0;

    // Pin the reference model to hand-computed results.
    m = model(64'd100, 64'd7, 1'b0, 1'b0);
    chk("model_100_7_q", m.q, 64'd14);
    chk("model_100_7_r", m.r, 64'd2);
    chk("model_100_7_k", 64'(m.k), 64'd5);
    m = model(-64'sd7, 64'd2, 1'b1, 1'b0);
    chk("model_m7_2_q", m.q, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("model_m7_2_r", m.r, 64'hFFFF_FFFF_FFFF_FFFF);
    m = model(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1);
    chk("model_word_ovf_q", m.q, 64'hFFFF_FFFF_8000_0000);
    chk("model_word_ovf_k", 64'(m.k), 64'd0);

    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_ready", {63'b0, start_ready_o}, 64'd1);
    chk("rst_valid", {63'b0, finish_valid_o}, 64'd0);
    chk("rst_q", quotient_o, 64'd0);
    chk("rst_r", remainder_o, 64'd0);
    chk("rst_z", {63'b0, divisor_is_zero_o}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases with literal expectations.
    do_op(64'd100, 64'd7, 1'b0, 1'b0, 1, 64'd14, 64'd2, 1'b0, 0, "u100_7");
    do_op(-64'sd7, 64'd2, 1'b1, 1'b0, 1, 64'hFFFF_FFFF_FFFF_FFFD,
          64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, "s_m7_2");
    do_op(64'h1234, 64'd0, 1'b0, 1'b0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1'b1, 0, "div0");
    do_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1,
          64'h8000_0000_0000_0000, 64'd0, 1'b0, 0, "ovf");
    do_op(64'd5, 64'd9, 1'b0, 1'b0, 1, 64'd0, 64'd5, 1'b0, 0, "small");
    do_op(64'hDEAD_0000_0000_0009, 64'hBEEF_0000_0000_0002, 1'b0, 1'b1, 1,
          64'd4, 64'd1, 1'b0, 0, "w_u9_2");
    do_op(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 1,
          64'hFFFF_FFFF_8000_0000, 64'd0, 1'b0, 0, "w_ovf");
    do_op(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 1,
          64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 0, "w_umax");
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1,
          64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 0, "umax_1");

    // Backpressure for 5 cycles in DONE.
    do_op(64'd1000, 64'd33, 1'b0, 1'b0, 1, 64'd30, 64'd10, 1'b0, 5, "bp");

    // Flush with start_valid in IDLE must block acceptance.
    start_valid_i = 1'b1;
    flush_i       = 1'b1;
    dividend_i    = 64'd50;
    divisor_i     = 64'd5;
    @(posedge clk); #1;
    start_valid_i = 1'b0;
    flush_i       = 1'b0;
    chk("idle_flush_blocks", {63'b0, start_ready_o}, 64'd1);

    // Flush in the third ITER cycle of a 64-iteration operation.
    start_valid_i = 1'b1;
    signed_op_i   = 1'b0;
    word_op_i     = 1'b0;
    dividend_i    = 64'hFFFF_FFFF_FFFF_FFFF;
    divisor_i     = 64'd1;
    @(posedge clk); #1;
    start_valid_i = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush_ready", {63'b0, start_ready_o}, 64'd1);
    chk("flush_valid", {63'b0, finish_valid_o}, 64'd0);
    repeat (70) begin
      @(posedge clk); #1;
    end
    do_op(64'd10, 64'd3, 1'b0, 1'b0, 1, 64'd3, 64'd1, 1'b0, 0, "after_flush");

    // Asynchronous reset in the middle of ITER.
    start_valid_i = 1'b1;
    dividend_i    = 64'hFFFF_FFFF_FFFF_FFFF;
    divisor_i     = 64'd3;
    @(posedge clk); #1;
    start_valid_i = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("midrst_ready", {63'b0, start_ready_o}, 64'd1);
    chk("midrst_valid", {63'b0, finish_valid_o}, 64'd0);
    chk("midrst_q", quotient_o, 64'd0);
    chk("midrst_r", remainder_o, 64'd0);
    chk("midrst_z", {63'b0, divisor_is_zero_o}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (70) begin
      @(posedge clk); #1;
    end
    chk("midrst_no_valid", {63'b0, finish_valid_o}, 64'd0);

    // Randomized operations checked by the compare process.
    for (int n = 0; n < 250; n++) begin
      s = 1'($urandom);
      w = 1'($urandom);
      a = {$urandom, $urandom} >> $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1) a = -a;
      case ($urandom_range(0, 15))
        0:       b = 64'd0;
        1:       b = '1;
        2:       b = w ? {32'b0, 32'hFFFF_FFFF} : '1;
        default: b = {$urandom, $urandom} >> $urandom_range(0, 63);
      endcase
      case ($urandom_range(0, 15))
        0:       a = 64'h8000_0000_0000_0000;
        1:       a = 64'h0000_0000_8000_0000;
        default: ;
      endcase
      do_op(a, b, s, w, 0, 64'd0, 64'd0, 1'b0, $urandom_range(0, 2), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
